// File: rtl/lsu_unit.sv
// Load/store unit: one outstanding byte/half/word access to a word-addressed memory,
// with lane steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_unit #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_op,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic [4:0]           rsp_rd,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [3:0]           mem_be,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t               state, state_next;
    logic                 lat_we;
    logic [2:0]           lat_op;
    logic [1:0]           lat_off;
    logic [4:0]           lat_rd;
    logic                 req_bad;
    logic [3:0]           be_calc;
    logic [WORD_SIZE-1:0] wdata_calc;
    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic [WORD_SIZE-1:0] load_data;

    always_comb begin
        req_bad = 1'b0;
        case (req_op)
            3'b000:  req_bad = 1'b0;
            3'b001:  req_bad = req_addr[0];
            3'b010:  req_bad = (req_addr[1:0] != 2'b00);
            3'b100:  req_bad = req_we;
            3'b101:  req_bad = req_we | req_addr[0];
            default: req_bad = 1'b1;
        endcase
    end

    // Byte enables and store lanes depend only on access size, so op[1:0] is enough.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
        case (req_op[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << req_addr[1:0];
                wdata_calc = {2{req_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = req_wdata;
            end
        endcase
    end

    always_comb begin
        sel_byte = mem_rdata[7:0];
        case (lat_off)
            2'd0: sel_byte = mem_rdata[7:0];
            2'd1: sel_byte = mem_rdata[15:8];
            2'd2: sel_byte = mem_rdata[23:16];
            2'd3: sel_byte = mem_rdata[31:24];
            default: sel_byte = mem_rdata[7:0];
        endcase
        sel_half  = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (lat_op)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_bad ? RESP : REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory-side fields are only loaded for legal requests, so an illegal one never disturbs them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_op    <= 3'd0;
            lat_off   <= 2'd0;
            lat_rd    <= 5'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'd0;
            mem_wdata <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            rsp_rd    <= 5'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                lat_we  <= req_we;
                lat_op  <= req_op;
                lat_off <= req_addr[1:0];
                lat_rd  <= req_rd;
                if (req_bad) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_rd    <= 5'd0;
                end else begin
                    rsp_err   <= 1'b0;
                    mem_we    <= req_we;
                    mem_addr  <= {req_addr[WORD_SIZE-1:2], 2'b00};
                    mem_be    <= be_calc;
                    mem_wdata <= wdata_calc;
                end
            end
            if (state == WAIT && mem_rvalid) begin
                rsp_rdata <= lat_we ? '0 : load_data;
                rsp_rd    <= lat_we ? 5'd0 : lat_rd;
            end
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized transactions
// compared against an arithmetic reference model of the load/store rules.
module tb_lsu_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;
    int          last_cycles;

    lsu_unit #(.WORD_SIZE(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .rsp_rd     (rsp_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Access size in bytes; 0 marks an unsupported funct3.
    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_bad(input logic we, input logic [2:0] op, input logic [31:0] addr);
        int sz;
        sz = op_size(op);
        if (sz == 0) return 1'b1;
        if (we && op[2]) return 1'b1;
        return (int'(addr[1:0]) % sz) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
        int sz;
        sz = op_size(op);
        return 4'(((1 << sz) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wdata);
        logic [31:0] out;
        int sz;
        sz  = op_size(op);
        out = '0;
        for (int i = 0; i < 4; i++) out[8*i +: 8] = wdata[8*(i % sz) +: 8];
        return out;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] val, mask;
        int sz;
        sz   = op_size(op);
        val  = rdata >> (8 * int'(addr[1:0]));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        val  = val & mask;
        if (!op[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
        return val;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkFlag({tag, "_req_ready"}, req_ready, 1'b1);
        checkFlag({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        checkFlag({tag, "_rsp_err"}, rsp_err, 1'b0);
        checkFlag({tag, "_mem_req"}, mem_req, 1'b0);
        checkFlag({tag, "_mem_we"}, mem_we, 1'b0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, "_rsp_rd"}, {27'd0, rsp_rd}, 32'd0);
    endtask

    // One complete transaction; memory grant and read-valid delays are in cycles.
    task automatic applyStimulus(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
        bit bad;
        int cyc;
        bad = model_bad(we, op, addr);
        @(negedge clk);
        checkFlag("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        @(negedge clk);
        cyc       = 1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
        if (bad) begin
            checkFlag("err_rsp_valid", rsp_valid, 1'b1);
            checkFlag("err_rsp_err", rsp_err, 1'b1);
            checkOutput("err_rsp_rdata", rsp_rdata, 32'd0);
            checkOutput("err_rsp_rd", {27'd0, rsp_rd}, 32'd0);
            checkFlag("err_no_mem_req", mem_req, 1'b0);
        end else begin
            for (int k = 0; k <= gnt_dly; k++) begin
                checkFlag("req_mem_req", mem_req, 1'b1);
                checkFlag("req_ready_busy", req_ready, 1'b0);
                checkFlag("req_mem_we", mem_we, we);
                checkOutput("req_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                checkOutput("req_mem_be", {28'd0, mem_be}, {28'd0, model_be(op, addr)});
                if (we) checkOutput("req_mem_wdata", mem_wdata, model_wdata(op, wdata));
                if (k == gnt_dly) begin
                    mem_gnt = 1'b1;
                end else begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                    mem_rdata  = $urandom;
                end
                @(negedge clk);
                cyc++;
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
            end
            checkFlag("wait_mem_req", mem_req, 1'b0);
            for (int k = 0; k < rv_dly; k++) begin
                @(negedge clk);
                cyc++;
                checkFlag("wait_no_rsp", rsp_valid, 1'b0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            checkFlag("rsp_valid", rsp_valid, 1'b1);
            checkFlag("rsp_err", rsp_err, 1'b0);
            checkOutput("rsp_rdata", rsp_rdata, we ? 32'd0 : model_load(op, addr, rdata));
            checkOutput("rsp_rd", {27'd0, rsp_rd}, we ? 32'd0 : {27'd0, rd});
        end
        last_rdata  = rsp_rdata;
        last_cycles = cyc;
        @(negedge clk);
        checkFlag("rsp_one_cycle", rsp_valid, 1'b0);
        checkFlag("ready_after_rsp", req_ready, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_op     = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;

        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // LB from the top lane with immediate grant and data: minimum latency.
        applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd3, 32'h80FF_0000, 0, 0);
        checkOutput("lb_rdata_const", last_rdata, 32'hFFFF_FF80);
        checkOutput("lb_latency", 32'(last_cycles), 32'd3);

        applyStimulus(1'b0, 3'b101, 32'h0000_0202, 32'd0, 5'd9, 32'h9ABC_1234, 0, 0);
        checkOutput("lhu_rdata_const", last_rdata, 32'h0000_9ABC);

        // SB with a slow grant: request fields must hold for five cycles.
        applyStimulus(1'b1, 3'b000, 32'h0000_0031, 32'h1234_56A5, 5'd7, 32'hDEAD_BEEF, 4, 1);

        applyStimulus(1'b0, 3'b010, 32'h0000_0042, 32'd0, 5'd4, 32'd0, 0, 0);
        checkOutput("err_latency", 32'(last_cycles), 32'd1);
        applyStimulus(1'b0, 3'b110, 32'h0000_0040, 32'd0, 5'd4, 32'd0, 0, 0);
        applyStimulus(1'b1, 3'b100, 32'h0000_0040, 32'd0, 5'd4, 32'd0, 0, 0);
        applyStimulus(1'b1, 3'b001, 32'h0000_1002, 32'hDEAD_BEEF, 5'd1, 32'd0, 1, 2);
        applyStimulus(1'b0, 3'b001, 32'h0000_1002, 32'd0, 5'd2, 32'h8001_7FFF, 0, 1);
        applyStimulus(1'b0, 3'b100, 32'h0000_1001, 32'd0, 5'd5, 32'h0000_F000, 2, 0);
        applyStimulus(1'b1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 5'd6, 32'd0, 0, 0);

        // Reset while waiting for read data: the late data must not produce a response.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_op    = 3'b010;
        req_addr  = 32'h0000_0500;
        req_rd    = 5'd11;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkFlag("pre_reset_wait", mem_req, 1'b0);
        rst = 1'b1;
        #1;
        checkIdleOutputs("mid_reset");
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            checkFlag("post_reset_no_rsp", rsp_valid, 1'b0);
            checkFlag("post_reset_ready", req_ready, 1'b1);
        end
        applyStimulus(1'b0, 3'b010, 32'h0000_0600, 32'd0, 5'd12, 32'h1357_9BDF, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [31:0] addr;
            op   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = (op[1:0] == 2'b10) ? 2'b00 :
                                                      (op[1:0] == 2'b01) ? {addr[1], 1'b0} : addr[1:0];
            applyStimulus(1'($urandom), op, addr, $urandom, 5'($urandom), $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 Parameter: WORD_SIZE, 32, data/address width; only 32 SHALL be supported.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  core presents a load/store.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  WORD_SIZE  byte address.
REQ-010 req_wdata  in  WORD_SIZE  store data, right-aligned.
REQ-011 req_rd  in  5  load destination register.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_err  out  1  misaligned or illegal op; qualified by rsp_valid.
REQ-014 rsp_rdata  out  WORD_SIZE  extended load data; 0 for stores and errors.
REQ-015 rsp_rd  out  5  latched req_rd for loads; 0 for stores and errors.
REQ-016 mem_req  out  1  memory request, held until grant.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_addr  out  WORD_SIZE  word address, bits [1:0] = 0.
REQ-019 mem_be  out  4  byte enables.
REQ-020 mem_wdata  out  WORD_SIZE  lane-replicated store data.
REQ-021 mem_gnt  in  1  memory accepts the request.
REQ-022 mem_rvalid  in  1  read data or write acknowledge.
REQ-023 mem_rdata  in  WORD_SIZE  read word.

Function
REQ-024 States SHALL be IDLE, REQ, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-025 IDLE, req_valid=1: latch we/op/addr/wdata/rd; go to REQ, or to RESP with error flagged if the request is invalid.
REQ-026 Invalid request: H/HU with addr[0]=1; W with addr[1:0]!=0; op 011/110/111; op 100/101 with we=1.
REQ-027 An invalid request SHALL NOT assert mem_req.
REQ-028 REQ: mem_req=1 with registered mem_* fields stable; on mem_gnt=1 go to WAIT.
REQ-029 mem_rvalid in IDLE, REQ or RESP SHALL be ignored; earliest valid rvalid is the cycle after gnt.
REQ-030 WAIT: on mem_rvalid=1, register the response, then go to RESP.
  - loads: lane selected by addr[1:0] (B/BU) or addr[1] (H/HU); B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-031 RESP: rsp_valid=1 for exactly one cycle, then IDLE.
REQ-032 mem_be: B/BU = 0001<<addr[1:0]; H/HU = 0011<<addr[1:0]; W = 1111; identical for loads and stores.
REQ-033 mem_wdata: SB = wdata[7:0] x4; SH = wdata[15:0] x2; SW = wdata.
REQ-034 Minimum latency: accept cycle N, gnt in N+1, rvalid in N+2, rsp_valid in N+3; an error response has rsp_valid in N+1.
REQ-035 Only one transaction SHALL be outstanding; no request is accepted before return to IDLE.

Reset
REQ-036 On rst, in any state: state=IDLE; req_ready=1; rsp_valid, rsp_err, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, rsp_rdata, rsp_rd = 0.
REQ-037 A transaction in flight at reset SHALL be abandoned with no response.
  - mem_rvalid arriving after reset SHALL be ignored.

Verification
REQ-038 LB, addr 0x103, mem_rdata 0x80FF_0000, gnt and rvalid immediate:
  - required: mem_addr 0x100, be 1000, rsp_rdata 0xFFFF_FF80, rsp_valid 3 cycles after accept.
REQ-039 LHU, addr 0x202, mem_rdata 0x9ABC_1234 -> be 1100, rsp_rdata 0x0000_9ABC.
REQ-040 SB, addr 0x31, wdata 0x1234_56A5, gnt delayed 4 cycles:
  - mem_req held 5 cycles with stable fields, wdata 0xA5A5_A5A5, be 0010;
  - rsp_rd 0, rsp_err 0.
REQ-041 LW, addr 0x42 -> rsp_valid and rsp_err 1 the cycle after accept, mem_req never 1; same for op 110.
REQ-042 rst asserted in WAIT, then rvalid pulsed -> all outputs at reset values, no rsp_valid, next LW completes normally.
